al_commit_ctrl: RTL and testbench

- Pointer and commit controller for the partitioned active list.
- Owns the head, tail and occupancy state, and allocates tail slots to dispatch lanes.
- Drives the per-commit-lane read addresses into the active-list data/control RAMs and decides how many head entries retire each cycle.
- Sequences active-list partition reconfiguration: stall dispatch, drain, resize, restart.

---
 rtl/al_commit_ctrl_pkg.sv | 29 ++
 rtl/al_lead_ones_count.sv | 26 ++
 rtl/al_commit_ctrl.sv | 152 +++++++++++++++
 tb/tb_al_commit_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/al_commit_ctrl_pkg.sv
// Active-list commit controller shared types and helpers.
// FSM states, partition sizing and modulo pointer arithmetic.
package al_commit_ctrl_pkg;

  localparam int AL_DEPTH      = 128;
  localparam int AL_INDEX      = 7;
  localparam int AL_NUM_PARTS  = 4;
  localparam int AL_PART_DEPTH = AL_DEPTH / AL_NUM_PARTS;

  typedef enum logic [1:0] {
    AL_RUN    = 2'd0,
    AL_DRAIN  = 2'd1,
    AL_RECONF = 2'd2
  } al_state_e;

  // effDepth need not be a power of two, so wrap by subtraction
  function automatic logic [AL_INDEX-1:0] al_wrap_add(
    input logic [AL_INDEX-1:0] ptr,
    input logic [AL_INDEX:0]   n,
    input logic [AL_INDEX:0]   eff
  );
    logic [AL_INDEX:0] sum;
    sum = {1'b0, ptr} + n;
    if (sum >= eff)
      sum = sum - eff;
    return sum[AL_INDEX-1:0];
  endfunction

endpackage

// File: rtl/al_lead_ones_count.sv
// Leading-ones counter from bit 0 upward.
// Produces the run length and the matching thermometer mask.
module al_lead_ones_count #(
  parameter int W  = 4,
  parameter int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt,
  output logic [W-1:0]  mask
);

  logic run;

  always_comb begin
    run  = 1'b1;
    cnt  = '0;
    mask = '0;
    for (int i = 0; i < W; i++) begin
      run     = run & vec[i];
      mask[i] = run;
      if (run)
        cnt = CW'(i + 1);
    end
  end

endmodule

// File: rtl/al_commit_ctrl.sv
// Active-list head/tail/occupancy control, commit selection
// and partition reconfiguration sequencing.
module al_commit_ctrl
  import al_commit_ctrl_pkg::*;
#(
  parameter int COMMIT_WIDTH   = 4,
  parameter int DISPATCH_WIDTH = 4,
  parameter int DEPTH          = AL_DEPTH,
  parameter int INDEX          = AL_INDEX,
  parameter int NUM_PARTS      = AL_NUM_PARTS,
  parameter int NUM_PARTS_LOG  = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush_i,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]    dispatchCnt_i,
  input  logic [DISPATCH_WIDTH-1:0]              dispatchLaneActive_i,
  input  logic [COMMIT_WIDTH-1:0]                commitLaneActive_i,
  input  logic [COMMIT_WIDTH-1:0]                commitReady_i,
  input  logic [NUM_PARTS-1:0]                   alPartitionActive_i,
  input  logic                                   reconfigReq_i,
  output logic [DISPATCH_WIDTH-1:0][INDEX-1:0]   addrWr_o,
  output logic [COMMIT_WIDTH-1:0][INDEX-1:0]     addr_o,
  output logic [COMMIT_WIDTH-1:0]                commitValid_o,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0]      commitCnt_o,
  output logic [INDEX:0]                         alCount_o,
  output logic                                   alFull_o,
  output logic                                   alEmpty_o,
  output logic                                   stallDispatch_o,
  output logic                                   reconfigDone_o
);

  localparam int CCW  = $clog2(COMMIT_WIDTH+1);
  localparam int PART = DEPTH / NUM_PARTS;

  al_state_e state_q, state_d;

  logic [INDEX-1:0]        head_q, tail_q;
  logic [INDEX:0]          count_q, count_d;
  logic [INDEX:0]          eff_q, eff_new;
  logic [INDEX:0]          free_cnt, acc, ret;
  logic [NUM_PARTS-1:0]    pend_q;
  logic [NUM_PARTS_LOG:0]  parts;
  logic [COMMIT_WIDTH-1:0] occ, cand, lead_mask;
  logic [CCW-1:0]          lead_cnt;

  // an all-zero mask is treated as a single partition
  always_comb begin
    parts = '0;
    for (int i = 0; i < NUM_PARTS; i++)
      parts = parts + (NUM_PARTS_LOG+1)'(pend_q[i]);
    if (parts == '0)
      parts = (NUM_PARTS_LOG+1)'(1);
    eff_new = (INDEX+1)'(parts) * (INDEX+1)'(PART);
  end

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++)
      occ[i] = count_q > (INDEX+1)'(i);
  end

  assign cand = commitReady_i & commitLaneActive_i & occ;

  al_lead_ones_count #(
    .W (COMMIT_WIDTH)
  ) u_lead (
    .vec  (cand),
    .cnt  (lead_cnt),
    .mask (lead_mask)
  );

  assign commitValid_o = flush_i ? '0 : lead_mask;
  assign commitCnt_o   = flush_i ? '0 : lead_cnt;
  assign ret           = (INDEX+1)'(commitCnt_o);

  assign free_cnt  = eff_q - count_q;
  assign alFull_o  = free_cnt < (INDEX+1)'(DISPATCH_WIDTH);
  assign alEmpty_o = count_q == '0;
  assign alCount_o = count_q;

  assign acc = (stallDispatch_o || flush_i) ?
               '0 : (INDEX+1)'(dispatchCnt_i);

  // commit sees the pre-cycle count, so new entries never retire early
  assign count_d = flush_i ? '0 : count_q + acc - ret;

  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      addrWr_o[i] = al_wrap_add(tail_q, (INDEX+1)'(i), eff_q);
    for (int i = 0; i < COMMIT_WIDTH; i++)
      addr_o[i] = al_wrap_add(head_q, (INDEX+1)'(i), eff_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= AL_RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AL_RUN:    if (reconfigReq_i) state_d = AL_DRAIN;
      AL_DRAIN:  if (flush_i || count_q == '0) state_d = AL_RECONF;
      AL_RECONF: state_d = AL_RUN;
      default:   state_d = AL_RUN;
    endcase
  end

  always_comb begin
    stallDispatch_o = 1'b1;
    reconfigDone_o  = 1'b0;
    unique case (state_q)
      AL_RUN:    stallDispatch_o = alFull_o;
      AL_DRAIN:  stallDispatch_o = 1'b1;
      AL_RECONF: reconfigDone_o  = 1'b1;
      default:   stallDispatch_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      eff_q   <= (INDEX+1)'(DEPTH);
      pend_q  <= '1;
    end else begin
      count_q <= count_d;
      if (state_q == AL_RUN && reconfigReq_i)
        pend_q <= alPartitionActive_i;
      if (flush_i || state_q == AL_RECONF) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        head_q <= al_wrap_add(head_q, ret, eff_q);
        tail_q <= al_wrap_add(tail_q, acc, eff_q);
      end
      if (state_q == AL_RECONF)
        eff_q <= eff_new;
    end
  end

  al_mask_nonzero: assert property (@(posedge clk) disable iff (reset)
    (reconfigReq_i && state_q == AL_RUN) |-> (|alPartitionActive_i));

  al_dispatch_lanes: assert property (@(posedge clk) disable iff (reset)
    !stallDispatch_o |->
      (32'(dispatchCnt_i) <= $countones(dispatchLaneActive_i)));

endmodule

// File: tb/tb_al_commit_ctrl.sv
// Self-checking bench for al_commit_ctrl: constant vector table,
// directed corner sequences and randomized traffic vs a queue-level model.
module tb_al_commit_ctrl;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush_i;
  logic [2:0]       dispatchCnt_i;
  logic [3:0]       dispatchLaneActive_i;
  logic [3:0]       commitLaneActive_i;
  logic [3:0]       commitReady_i;
  logic [3:0]       alPartitionActive_i;
  logic             reconfigReq_i;
  logic [3:0][6:0]  addrWr_o;
  logic [3:0][6:0]  addr_o;
  logic [3:0]       commitValid_o;
  logic [2:0]       commitCnt_o;
  logic [7:0]       alCount_o;
  logic             alFull_o;
  logic             alEmpty_o;
  logic             stallDispatch_o;
  logic             reconfigDone_o;

  al_commit_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .flush_i              (flush_i),
    .dispatchCnt_i        (dispatchCnt_i),
    .dispatchLaneActive_i (dispatchLaneActive_i),
    .commitLaneActive_i   (commitLaneActive_i),
    .commitReady_i        (commitReady_i),
    .alPartitionActive_i  (alPartitionActive_i),
    .reconfigReq_i        (reconfigReq_i),
    .addrWr_o             (addrWr_o),
    .addr_o               (addr_o),
    .commitValid_o        (commitValid_o),
    .commitCnt_o          (commitCnt_o),
    .alCount_o            (alCount_o),
    .alFull_o             (alFull_o),
    .alEmpty_o            (alEmpty_o),
    .stallDispatch_o      (stallDispatch_o),
    .reconfigDone_o       (reconfigDone_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: phase 0 running, 1 draining, 2 resizing
  int         m_head, m_tail, m_count, m_eff, m_phase;
  logic [3:0] m_pend;

  always @(posedge clk)
    if (!reset)
      assert (int'(dispatchCnt_i) <= $countones(dispatchLaneActive_i));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
    m_eff   = 128;
    m_phase = 0;
    m_pend  = 4'hF;
  endtask

  function automatic int m_k();
    int k;
    k = 0;
    if (flush_i) return 0;
    for (int i = 0; i < 4; i++) begin
      if (i < m_count && commitReady_i[i] && commitLaneActive_i[i])
        k++;
      else
        break;
    end
    return k;
  endfunction

  function automatic bit m_full();
    return (m_eff - m_count) < 4;
  endfunction

  function automatic bit m_stall();
    return m_full() || m_phase != 0;
  endfunction

  task automatic cmp_model(input string tag);
    int k;
    k = m_k();
    chk({tag, " alCount"}, int'(alCount_o), m_count);
    chk({tag, " alEmpty"}, int'(alEmpty_o), int'(m_count == 0));
    chk({tag, " alFull"}, int'(alFull_o), int'(m_full()));
    chk({tag, " stall"}, int'(stallDispatch_o), int'(m_stall()));
    chk({tag, " done"}, int'(reconfigDone_o), int'(m_phase == 2));
    chk({tag, " commitCnt"}, int'(commitCnt_o), k);
    chk({tag, " commitValid"}, int'(commitValid_o), (1 << k) - 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s addr%0d", tag, i), int'(addr_o[i]),
          (m_head + i) % m_eff);
      chk($sformatf("%s addrWr%0d", tag, i), int'(addrWr_o[i]),
          (m_tail + i) % m_eff);
    end
  endtask

  task automatic m_update();
    int k, acc, nph, np;
    k   = m_k();
    acc = (!m_stall() && !flush_i) ? int'(dispatchCnt_i) : 0;
    nph = m_phase;
    if (m_phase == 0 && reconfigReq_i) nph = 1;
    if (m_phase == 1 && (flush_i || m_count == 0)) nph = 2;
    if (m_phase == 2) nph = 0;
    if (flush_i) begin
      m_head = 0; m_tail = 0; m_count = 0;
    end else begin
      m_head  = (m_head + k) % m_eff;
      m_tail  = (m_tail + acc) % m_eff;
      m_count = m_count + acc - k;
    end
    if (m_phase == 2) begin
      np = $countones(m_pend);
      m_eff  = (np == 0 ? 1 : np) * 32;
      m_head = 0;
      m_tail = 0;
    end
    if (m_phase == 0 && reconfigReq_i) m_pend = alPartitionActive_i;
    m_phase = nph;
  endtask

  task automatic drv(input int dc, input logic [3:0] rdy,
                     input logic fl, input logic rq,
                     input logic [3:0] msk,
                     input logic [3:0] dla = 4'hF,
                     input logic [3:0] cla = 4'hF);
    dispatchCnt_i        = 3'(dc);
    commitReady_i        = rdy;
    flush_i              = fl;
    reconfigReq_i        = rq;
    alPartitionActive_i  = msk;
    dispatchLaneActive_i = dla;
    commitLaneActive_i   = cla;
    #4;
  endtask

  task automatic tick(input string tag);
    cmp_model(tag);
    m_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         dc;
    logic [3:0] rdy;
    int         e_count;
    int         e_cc;
    logic [3:0] e_valid;
    int         e_wr0;
    int         e_rd0;
  } row_t;

  row_t tbl[5];
  int   drains;
  int   got;
  int   dc, pc, sel;
  logic [3:0] dla, cla, rdy, msk;
  logic fl, rq;

  initial begin
    tbl[0] = '{4, 4'h0,  0, 0, 4'h0,  0, 0};
    tbl[1] = '{4, 4'h0,  4, 0, 4'h0,  4, 0};
    tbl[2] = '{4, 4'h0,  8, 0, 4'h0,  8, 0};
    tbl[3] = '{0, 4'hB, 12, 2, 4'h3, 12, 0};
    tbl[4] = '{0, 4'h0, 10, 0, 4'h0, 12, 2};

    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    m_reset();
    #1 reset = 1'b1;
    #2;
    chk("reset alCount", int'(alCount_o), 0);
    chk("reset alEmpty", int'(alEmpty_o), 1);
    chk("reset alFull", int'(alFull_o), 0);
    chk("reset stall", int'(stallDispatch_o), 0);
    chk("reset done", int'(reconfigDone_o), 0);
    chk("reset commitCnt", int'(commitCnt_o), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int r = 0; r < 5; r++) begin
      drv(tbl[r].dc, tbl[r].rdy, 1'b0, 1'b0, 4'hF);
      chk($sformatf("tbl%0d count", r), int'(alCount_o), tbl[r].e_count);
      chk($sformatf("tbl%0d commitCnt", r), int'(commitCnt_o), tbl[r].e_cc);
      chk($sformatf("tbl%0d valid", r), int'(commitValid_o),
          int'(tbl[r].e_valid));
      chk($sformatf("tbl%0d addr0", r), int'(addr_o[0]), tbl[r].e_rd0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("tbl%0d addrWr%0d", r, i), int'(addrWr_o[i]),
            tbl[r].e_wr0 + i);
      tick("tbl");
    end

    // resize to two partitions, walk tail to 62 and fill to 61
    drv(0, 4'h0, 1'b1, 1'b0, 4'hF); tick("flush");
    drv(0, 4'h0, 1'b0, 1'b1, 4'h3); tick("req64");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF); tick("drain64");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("reconf64 done", int'(reconfigDone_o), 1);
    tick("reconf64");
    for (int i = 0; i < 15; i++) begin
      drv(4, 4'hF, 1'b0, 1'b0, 4'hF); tick("walk64");
    end
    drv(2, 4'hF, 1'b0, 1'b0, 4'hF); tick("walk64");
    drv(4, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("wrap64 wr0", int'(addrWr_o[0]), 62);
    chk("wrap64 wr1", int'(addrWr_o[1]), 63);
    chk("wrap64 wr2", int'(addrWr_o[2]), 0);
    chk("wrap64 wr3", int'(addrWr_o[3]), 1);
    tick("wrap64");
    for (int i = 0; i < 13; i++) begin
      drv(4, 4'h0, 1'b0, 1'b0, 4'hF); tick("fill");
    end
    drv(2, 4'h0, 1'b0, 1'b0, 4'hF); tick("fill");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("count60 full", int'(alFull_o), 0);
    tick("fill");
    drv(1, 4'h0, 1'b0, 1'b0, 4'hF); tick("fill");
    drv(4, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("count61 full", int'(alFull_o), 1);
    chk("count61 stall", int'(stallDispatch_o), 1);
    tick("full");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("held count", int'(alCount_o), 61);
    tick("full");

    // drain to a single partition, 2 retire per cycle
    drv(0, 4'h0, 1'b1, 1'b0, 4'hF); tick("flush");
    drv(4, 4'h0, 1'b0, 1'b0, 4'hF); tick("pre32");
    drv(4, 4'h0, 1'b0, 1'b0, 4'hF); tick("pre32");
    drv(0, 4'h3, 1'b0, 1'b1, 4'h1);
    chk("req32 commitCnt", int'(commitCnt_o), 2);
    tick("req32");
    drains = 0;
    got    = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      drv(0, 4'h3, 1'b0, 1'b0, 4'hF);
      if (reconfigDone_o) got = 1;
      else if (stallDispatch_o) drains++;
      tick("drain32");
    end
    chk("drain cycles", drains, 4);
    chk("reconf32 seen", got, 1);
    for (int i = 0; i < 7; i++) begin
      drv(4, 4'hF, 1'b0, 1'b0, 4'hF); tick("walk32");
    end
    drv(2, 4'hF, 1'b0, 1'b0, 4'hF); tick("walk32");
    drv(4, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("wrap32 wr0", int'(addrWr_o[0]), 30);
    chk("wrap32 wr1", int'(addrWr_o[1]), 31);
    chk("wrap32 wr2", int'(addrWr_o[2]), 0);
    chk("wrap32 wr3", int'(addrWr_o[3]), 1);
    tick("wrap32");

    // same-cycle dispatch and commit at count 1
    drv(0, 4'h0, 1'b1, 1'b0, 4'hF); tick("flush");
    drv(1, 4'h0, 1'b0, 1'b0, 4'hF); tick("one");
    drv(3, 4'h3, 1'b0, 1'b0, 4'hF);
    chk("occ commitCnt", int'(commitCnt_o), 1);
    chk("occ valid", int'(commitValid_o), 1);
    tick("occ");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("occ count", int'(alCount_o), 3);
    tick("occ");

    // flush while draining with 20 entries
    drv(0, 4'h0, 1'b1, 1'b0, 4'hF); tick("flush");
    for (int i = 0; i < 5; i++) begin
      drv(4, 4'h0, 1'b0, 1'b0, 4'hF); tick("load20");
    end
    drv(0, 4'h0, 1'b0, 1'b1, 4'hF); tick("req128");
    drv(0, 4'hF, 1'b1, 1'b0, 4'hF);
    chk("dflush commitCnt", int'(commitCnt_o), 0);
    chk("dflush count", int'(alCount_o), 20);
    tick("dflush");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("dflush after count", int'(alCount_o), 0);
    chk("dflush done", int'(reconfigDone_o), 1);
    tick("dflush");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("dflush run stall", int'(stallDispatch_o), 0);
    chk("dflush run done", int'(reconfigDone_o), 0);
    tick("dflush");

    // asynchronous reset in the middle of a drain
    drv(4, 4'h0, 1'b0, 1'b0, 4'hF); tick("pre_rst");
    drv(0, 4'h0, 1'b0, 1'b1, 4'h1); tick("pre_rst");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("mid drain stall", int'(stallDispatch_o), 1);
    #1 reset = 1'b1;
    #1;
    chk("arst count", int'(alCount_o), 0);
    chk("arst stall", int'(stallDispatch_o), 0);
    chk("arst empty", int'(alEmpty_o), 1);
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("post arst done", int'(reconfigDone_o), 0);
    tick("post_rst");
    drv(0, 4'h0, 1'b0, 1'b0, 4'hF);
    chk("post arst done2", int'(reconfigDone_o), 0);
    tick("post_rst");

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      dla = 4'($urandom);
      cla = 4'($urandom);
      pc  = $countones(dla);
      dc  = (pc == 0) ? 0 : int'($urandom_range(pc, 0));
      rdy = 4'($urandom);
      fl  = ($urandom_range(60, 0) == 0);
      rq  = ($urandom_range(40, 0) == 0);
      sel = int'($urandom_range(3, 0));
      msk = (sel == 0) ? 4'h1 : (sel == 1) ? 4'h3 :
            (sel == 2) ? 4'h7 : 4'hF;
      drv(dc, rdy, fl, rq, msk, dla, cla);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
